// File: rtl/kernal_params_loader_pkg.sv
// Shared definitions for the kernel-parameter loader.
//   - state_e      : loader FSM encoding (StIdle / StLoad / StDone)
//   - KERNAL_PAR_N : params per single-channel 3x3 kernel
//   - clogb2       : ceil(log2(n)), used to size counters
package kernal_params_loader_pkg;

   localparam int unsigned KERNAL_PAR_N = 9;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StLoad = 2'd1,
      StDone = 2'd2
   } state_e;

   function automatic int unsigned clogb2(input int unsigned n);
      int unsigned r;
      r = 0;
      while ((64'd1 << r) < 64'(n)) r = r + 1;
      return r;
   endfunction

   localparam int unsigned ParCntW = clogb2(KERNAL_PAR_N);

endpackage

// File: rtl/kernal_params_loader.sv
// Kernel-parameter loader: packs a stream of kernel params (one per AXIS beat) into
// 9-param 3x3 kernel words and writes one word per input channel into the buffer.
//
// Ports
//   clk_i            clock
//   rst_i            asynchronous reset, active-high
//   start_i          start pulse, accepted only while idle
//   chn_n_m1_i       input channel count - 1, latched on an accepted start
//   busy_o           high from accepted start until the done cycle
//   done_o           1-cycle pulse once every kernel is written
//   err_last_o       sticky tlast-mismatch flag, cleared by the next accepted start
//   s_axis_*         AXIS slave carrying the params
//   buffer_wen_o     buffer write enable
//   buffer_waddr_o   channel index being written
//   buffer_din_o     packed kernel, param k at [k*W +: W]
//
// Build option: define KERNAL_PARS_LOADER_LAST_CHK_EN to check s_axis_last_i against the
// expected final beat; otherwise tlast is ignored and err_last_o stays 0.
module kernal_params_loader
   import kernal_params_loader_pkg::*;
#(
   parameter int unsigned kernal_param_data_width = 16,
   parameter int unsigned max_feature_map_chn_n   = 512,
   parameter int unsigned simulation_delay        = 1
) (
   input  logic                                       clk_i,
   input  logic                                       rst_i,
   input  logic                                       start_i,
   input  logic [15:0]                                chn_n_m1_i,
   output logic                                       busy_o,
   output logic                                       done_o,
   output logic                                       err_last_o,
   input  logic [kernal_param_data_width-1:0]         s_axis_data_i,
   input  logic                                       s_axis_last_i,
   input  logic                                       s_axis_valid_i,
   output logic                                       s_axis_ready_o,
   output logic                                       buffer_wen_o,
   output logic [15:0]                                buffer_waddr_o,
   output logic [KERNAL_PAR_N*kernal_param_data_width-1:0] buffer_din_o
);

   localparam int unsigned W = kernal_param_data_width;
   localparam logic [15:0] ChnMaxM1 = 16'(max_feature_map_chn_n - 1);

   // Output delays are a simulation nicety only; the registers carry the real timing.
   logic unused_sim_delay;
   assign unused_sim_delay = ^simulation_delay;

   state_e                  state_q;
   logic [15:0]             chn_lim_q;
   logic [15:0]             chn_cnt_q;
   logic [ParCntW-1:0]      par_cnt_q;
   logic [W-1:0]            pack_q [KERNAL_PAR_N];
   logic                    last_pend_q;
   logic                    busy_q, done_q, err_q, ready_q, wen_q;
   logic [15:0]             waddr_q;
   logic [KERNAL_PAR_N*W-1:0] din_q;

   logic                    hs, last_par, last_chn, early_last, last_missing;
   logic [KERNAL_PAR_N*W-1:0] din_d;

   assign hs       = ready_q & s_axis_valid_i;
   assign last_par = (par_cnt_q == ParCntW'(KERNAL_PAR_N - 1));
   assign last_chn = (chn_cnt_q == chn_lim_q);

`ifdef KERNAL_PARS_LOADER_LAST_CHK_EN
   assign early_last   = s_axis_last_i & ~(last_par & last_chn);
   assign last_missing = ~s_axis_last_i & last_par & last_chn;
`else
   logic unused_last;
   assign unused_last  = s_axis_last_i;
   assign early_last   = 1'b0;
   assign last_missing = 1'b0;
`endif

   // Packed word for the write: the 9th param comes straight from the bus.
   always_comb begin
      din_d = '0;
      for (int k = 0; k < KERNAL_PAR_N; k++) begin
         din_d[k*W +: W] = (k == KERNAL_PAR_N - 1) ? s_axis_data_i : pack_q[k];
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= StIdle;
         chn_lim_q   <= '0;
         chn_cnt_q   <= '0;
         par_cnt_q   <= '0;
         pack_q      <= '{default: '0};
         last_pend_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         ready_q     <= 1'b0;
         wen_q       <= 1'b0;
         waddr_q     <= '0;
         din_q       <= '0;
      end else begin
         wen_q  <= 1'b0;
         done_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (start_i) begin
                  state_q     <= StLoad;
                  chn_lim_q   <= (chn_n_m1_i > ChnMaxM1) ? ChnMaxM1 : chn_n_m1_i;
                  chn_cnt_q   <= '0;
                  par_cnt_q   <= '0;
                  err_q       <= 1'b0;
                  last_pend_q <= 1'b0;
                  busy_q      <= 1'b1;
                  ready_q     <= 1'b1;
               end
            end
            StLoad: begin
               if (last_pend_q) begin
                  // Final write went out last cycle.
                  state_q     <= StDone;
                  last_pend_q <= 1'b0;
                  done_q      <= 1'b1;
                  busy_q      <= 1'b0;
               end else if (hs) begin
                  pack_q[par_cnt_q] <= s_axis_data_i;
                  if (last_par) begin
                     par_cnt_q <= '0;
                     wen_q     <= 1'b1;
                     waddr_q   <= chn_cnt_q;
                     din_q     <= din_d;
                     chn_cnt_q <= chn_cnt_q + 16'd1;
                     if (last_chn || early_last) begin
                        last_pend_q <= 1'b1;
                        ready_q     <= 1'b0;
                     end
                     if (early_last || last_missing) err_q <= 1'b1;
                  end else if (early_last) begin
                     // Premature tlast: drop the partial group and finish now.
                     par_cnt_q <= '0;
                     err_q     <= 1'b1;
                     state_q   <= StDone;
                     done_q    <= 1'b1;
                     busy_q    <= 1'b0;
                     ready_q   <= 1'b0;
                  end else begin
                     par_cnt_q <= par_cnt_q + ParCntW'(1);
                  end
               end
            end
            StDone: begin
               state_q <= StIdle;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign busy_o         = busy_q;
   assign done_o         = done_q;
   assign err_last_o     = err_q;
   assign s_axis_ready_o = ready_q;
   assign buffer_wen_o   = wen_q;
   assign buffer_waddr_o = waddr_q;
   assign buffer_din_o   = din_q;

endmodule

// File: tb/tb_kernal_params_loader.sv
// Self-checking bench for kernal_params_loader (default W=16, max channels 512).
// A reference model packs each 9-beat group as it is driven and queues the expected
// write; a monitor pops and compares on every buffer write.
module tb_kernal_params_loader;

   localparam int W = 16;
   localparam int N = 9;

   typedef struct {
      logic [15:0]      addr;
      logic [N*W-1:0]   din;
   } wr_t;

   logic               clk, rst, start, valid, last, ready;
   logic [15:0]        chn;
   logic [W-1:0]       data;
   logic               busy, done, err, wen;
   logic [15:0]        waddr;
   logic [N*W-1:0]     din;

   int n_vec = 0;
   int n_err = 0;
   int n_writes = 0;

   wr_t              exp_q[$];
   int               beat_no, grp_idx, exp_addr;
   logic [N*W-1:0]   grp;

   kernal_params_loader dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .start_i        (start),
      .chn_n_m1_i     (chn),
      .busy_o         (busy),
      .done_o         (done),
      .err_last_o     (err),
      .s_axis_data_i  (data),
      .s_axis_last_i  (last),
      .s_axis_valid_i (valid),
      .s_axis_ready_o (ready),
      .buffer_wen_o   (wen),
      .buffer_waddr_o (waddr),
      .buffer_din_o   (din)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   // Scoreboard consumer.
   always @(negedge clk) begin : mon
      wr_t e;
      if (!rst && wen) begin
         n_writes++;
         n_vec++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_write got addr=%0d din=%h, expected no write", waddr, din);
         end else begin
            e = exp_q.pop_front();
            if (waddr !== e.addr || din !== e.din) begin
               n_err++;
               $display("FAIL write_data got addr=%0d din=%h, expected addr=%0d din=%h",
                        waddr, din, e.addr, e.din);
            end
         end
      end
   end

   task automatic model_start();
      beat_no  = 0;
      grp_idx  = 0;
      exp_addr = 0;
      grp      = '0;
   endtask

   task automatic pulse_start(input logic [15:0] c);
      @(negedge clk);
      start = 1'b1;
      chn   = c;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Drives n beats; tlast on global beat numbers last_at or final_at.
   task automatic drive_beats(input int n, input bit rnd, input bit seq, input int last_at,
                              input int final_at);
      for (int i = 0; i < n; i++) begin
         bit          hs;
         int          guard;
         logic [W-1:0] d;
         beat_no++;
         d     = seq ? W'(beat_no) : W'($urandom);
         hs    = 1'b0;
         guard = 0;
         while (!hs && guard < 200) begin
            @(negedge clk);
            valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            data  = d;
            last  = (beat_no == last_at) || (beat_no == final_at);
            hs    = valid && ready;
            @(posedge clk);
            guard++;
         end
         #1 valid = 1'b0;
         last = 1'b0;
         if (!hs) begin
            n_vec++;
            n_err++;
            $display("FAIL beat_timeout got no handshake for beat %0d, expected ready", beat_no);
            return;
         end
         grp[grp_idx*W +: W] = d;
         if (grp_idx == N - 1) begin
            exp_q.push_back('{addr: exp_addr[15:0], din: grp});
            exp_addr++;
            grp_idx = 0;
         end else begin
            grp_idx++;
         end
      end
   endtask

   task automatic wait_done(input int budget, output int cyc);
      cyc = -1;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (done) begin
            cyc = i;
            break;
         end
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      n_vec++;
      if ({busy, done, err, ready, wen, waddr, din} !== '0) begin
         n_err++;
         $display("FAIL reset_outputs got busy=%b done=%b err=%b rdy=%b wen=%b addr=%0d, expected 0",
                  busy, done, err, ready, wen, waddr);
      end
      rst = 1'b0;
      @(negedge clk);
      @(negedge clk);
      n_vec++;
      if (ready !== 1'b0 || busy !== 1'b0) begin
         n_err++;
         $display("FAIL idle_ready got rdy=%b busy=%b, expected 0 0", ready, busy);
      end
   endtask

   task automatic test_single();
      logic [N*W-1:0] exp1;
      exp1 = 144'h0009_0008_0007_0006_0005_0004_0003_0002_0001;
      model_start();
      pulse_start(16'd0);
      n_vec++;
      if (busy !== 1'b1 || ready !== 1'b1) begin
         n_err++;
         $display("FAIL single_start got busy=%b rdy=%b, expected 1 1", busy, ready);
      end
      drive_beats(9, 1'b0, 1'b1, 0, 9);
      @(negedge clk);
      n_vec++;
      if (wen !== 1'b1 || done !== 1'b0 || din !== exp1 || waddr !== 16'd0) begin
         n_err++;
         $display("FAIL single_write got wen=%b done=%b addr=%0d din=%h, expected 1 0 0 %h",
                  wen, done, waddr, din, exp1);
      end
      @(negedge clk);
      n_vec++;
      if (done !== 1'b1 || wen !== 1'b0 || busy !== 1'b0) begin
         n_err++;
         $display("FAIL single_done got done=%b wen=%b busy=%b, expected 1 0 0", done, wen, busy);
      end
      @(negedge clk);
      n_vec++;
      if (done !== 1'b0 || ready !== 1'b0) begin
         n_err++;
         $display("FAIL single_idle got done=%b rdy=%b, expected 0 0", done, ready);
      end
   endtask

   task automatic test_random_valid();
      int w0, cyc;
      w0 = n_writes;
      model_start();
      pulse_start(16'd3);
      drive_beats(36, 1'b1, 1'b0, 0, 36);
      wait_done(5, cyc);
      n_vec++;
      if (cyc != 1) begin
         n_err++;
         $display("FAIL rand_done_latency got %0d, expected 1", cyc);
      end
      n_vec++;
      if (n_writes - w0 != 4 || exp_q.size() != 0) begin
         n_err++;
         $display("FAIL rand_write_count got %0d pending=%0d, expected 4 0",
                  n_writes - w0, exp_q.size());
      end
      @(negedge clk);
      n_vec++;
      if (busy !== 1'b0) begin
         n_err++;
         $display("FAIL rand_busy got %b, expected 0", busy);
      end
   endtask

   task automatic test_clamp();
      int w0, cyc;
      w0 = n_writes;
      model_start();
      pulse_start(16'd1000);
      drive_beats(4608, 1'b0, 1'b0, 0, 4608);
      @(negedge clk);
      n_vec++;
      if (ready !== 1'b0 || wen !== 1'b1 || waddr !== 16'd511) begin
         n_err++;
         $display("FAIL clamp_final got rdy=%b wen=%b addr=%0d, expected 0 1 511",
                  ready, wen, waddr);
      end
      wait_done(4, cyc);
      n_vec++;
      if (cyc != 0 || n_writes - w0 != 512 || exp_q.size() != 0) begin
         n_err++;
         $display("FAIL clamp_count got done_lat=%0d writes=%0d, expected 0 512",
                  cyc, n_writes - w0);
      end
   endtask

   task automatic test_last();
      int w0, cyc;
      w0 = n_writes;
      model_start();
      pulse_start(16'd2);
`ifdef KERNAL_PARS_LOADER_LAST_CHK_EN
      drive_beats(13, 1'b0, 1'b0, 13, 27);
      @(negedge clk);
      n_vec++;
      if (done !== 1'b1 || err !== 1'b1 || ready !== 1'b0) begin
         n_err++;
         $display("FAIL early_last got done=%b err=%b rdy=%b, expected 1 1 0", done, err, ready);
      end
      @(negedge clk);
      n_vec++;
      if (n_writes - w0 != 1 || exp_q.size() != 0 || err !== 1'b1) begin
         n_err++;
         $display("FAIL early_last_writes got %0d err=%b, expected 1 1", n_writes - w0, err);
      end
`else
      drive_beats(27, 1'b0, 1'b0, 13, 27);
      wait_done(5, cyc);
      n_vec++;
      if (cyc != 1 || err !== 1'b0) begin
         n_err++;
         $display("FAIL last_ignored got done_lat=%0d err=%b, expected 1 0", cyc, err);
      end
      n_vec++;
      if (n_writes - w0 != 3 || exp_q.size() != 0) begin
         n_err++;
         $display("FAIL last_ignored_writes got %0d, expected 3", n_writes - w0);
      end
`endif
   endtask

   task automatic test_start_busy();
      int w0, cyc;
      w0 = n_writes;
      model_start();
      pulse_start(16'd2);
      n_vec++;
      if (err !== 1'b0) begin
         n_err++;
         $display("FAIL err_clear_on_start got %b, expected 0", err);
      end
      drive_beats(5, 1'b0, 1'b0, 0, 27);
      @(negedge clk);
      start = 1'b1;
      chn   = 16'd7;
      @(negedge clk);
      start = 1'b0;
      drive_beats(22, 1'b1, 1'b0, 0, 27);
      wait_done(5, cyc);
      n_vec++;
      if (cyc != 1) begin
         n_err++;
         $display("FAIL start_busy_done got %0d, expected 1", cyc);
      end
      repeat (3) @(negedge clk);
      n_vec++;
      if (n_writes - w0 != 3 || busy !== 1'b0 || ready !== 1'b0 || exp_q.size() != 0) begin
         n_err++;
         $display("FAIL start_busy_writes got %0d busy=%b rdy=%b, expected 3 0 0",
                  n_writes - w0, busy, ready);
      end
   endtask

   task automatic test_reset_mid();
      int w0, cyc;
      w0 = n_writes;
      model_start();
      pulse_start(16'd5);
      drive_beats(14, 1'b0, 1'b0, 0, 54);
      @(negedge clk);
      rst = 1'b1;
      #1;
      n_vec++;
      if ({busy, done, err, ready, wen, waddr, din} !== '0) begin
         n_err++;
         $display("FAIL mid_reset_outputs got busy=%b rdy=%b wen=%b addr=%0d, expected 0",
                  busy, ready, wen, waddr);
      end
      @(negedge clk);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      n_vec++;
      if (n_writes - w0 != 1 || exp_q.size() != 0 || ready !== 1'b0) begin
         n_err++;
         $display("FAIL mid_reset_writes got %0d rdy=%b, expected 1 0", n_writes - w0, ready);
      end
      model_start();
      pulse_start(16'd0);
      drive_beats(9, 1'b0, 1'b0, 0, 9);
      wait_done(5, cyc);
      n_vec++;
      if (cyc != 1 || n_writes - w0 != 2 || exp_q.size() != 0) begin
         n_err++;
         $display("FAIL mid_reset_restart got done_lat=%0d writes=%0d, expected 1 2",
                  cyc, n_writes - w0);
      end
   endtask

   initial begin
      rst   = 1'b1;
      start = 1'b0;
      chn   = '0;
      valid = 1'b0;
      last  = 1'b0;
      data  = '0;
      test_reset();
      test_single();
      test_random_valid();
      test_clamp();
      test_last();
      test_start_busy();
      test_reset_mid();
      n_vec++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL leftover_expected got %0d pending, expected 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
